// File: rtl/sw_debouncer_if.sv
// Switch-conditioning bundle: raw pins in, debounced levels, edge pulses
// and the sticky event record out.
interface sw_debouncer_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] event_latched;
  logic             event_pending;
  logic             event_clear;

  modport master (
    output sw_raw, event_clear,
    input  sw_stable, sw_rise, sw_fall, event_latched, event_pending
  );

  modport slave (
    input  sw_raw, event_clear,
    output sw_stable, sw_rise, sw_fall, event_latched, event_pending
  );
endinterface

// File: rtl/sw_debouncer.sv
// Slide-switch conditioner: per-bit 2-flop sync, bounce filter, edge pulses
// and a sticky change record that software polls and clears.
module sw_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic clear,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic latched
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      latched <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      // set beats clear so a pulse coinciding with a clear is never lost
      latched <= (latched & ~clear) | rise | fall;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt    <= '0;
        stable <= s2;
        rise   <= s2;
        fall   <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module sw_debouncer #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic           clock,
  input  logic           reset,
  sw_debouncer_if.slave  bus
);
  logic [WIDTH-1:0] stable, rise, fall, latched;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sw_debouncer_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .raw     (bus.sw_raw[i]),
      .clear   (bus.event_clear),
      .stable  (stable[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .latched (latched[i])
    );
  end

  assign bus.sw_stable     = stable;
  assign bus.sw_rise       = rise;
  assign bus.sw_fall       = fall;
  assign bus.event_latched = latched;
  assign bus.event_pending = |latched;
endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer at DEBOUNCE_CYCLES=4, WIDTH=5.
module tb_sw_debouncer;
  localparam int W = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  sw_debouncer_if #(.WIDTH(W)) bus ();

  sw_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // one active edge; inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    bus.sw_raw = '0; bus.event_clear = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.event_latched, bus.event_pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b %b %b %b %b, want all 0", bus.sw_stable, bus.sw_rise,
               bus.sw_fall, bus.event_latched, bus.event_pending);
    end
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_rise();
    bus.sw_raw = 5'b00001;
    for (int t = 0; t < 5; t++) tick();
    n_tests++;
    if (bus.sw_stable !== 5'b00000 || bus.sw_rise !== 5'b00000) begin
      n_fail++;
      $display("FAIL rise_early: stable=%b rise=%b, want 00000 00000", bus.sw_stable, bus.sw_rise);
    end
    tick();
    n_tests++;
    if (bus.sw_stable !== 5'b00001 || bus.sw_rise !== 5'b00001 || bus.sw_fall !== 5'b00000) begin
      n_fail++;
      $display("FAIL rise_edge5: stable=%b rise=%b fall=%b, want 00001 00001 00000",
               bus.sw_stable, bus.sw_rise, bus.sw_fall);
    end
    tick();
    n_tests++;
    if (bus.sw_rise !== 5'b00000 || bus.event_latched !== 5'b00001 || bus.event_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_latch: rise=%b latched=%b pending=%b, want 00000 00001 1",
               bus.sw_rise, bus.event_latched, bus.event_pending);
    end
    bus.event_clear = 1'b1;
    tick();
    bus.event_clear = 1'b0;
    n_tests++;
    if (bus.event_latched !== 5'b00000 || bus.event_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_clear: latched=%b pending=%b, want 00000 0", bus.event_latched, bus.event_pending);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    bus.sw_raw = 5'b00011;
    for (int t = 0; t < 13; t++) begin
      if (t == 3) bus.sw_raw = 5'b00001;
      tick();
      if (bus.sw_rise !== 5'b0 || bus.sw_fall !== 5'b0 || bus.sw_stable !== 5'b00001 ||
          bus.event_pending !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL glitch_reject: %0d cycles with activity, want 0", bad);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seq;
    int rises = 0;
    int hit_t = -1;
    seq = 4'b0101;  // applied LSB first: 1,0,1,0
    for (int t = 0; t < 16; t++) begin
      if (t < 4) bus.sw_raw = {2'b00, seq[t], 2'b01};
      else       bus.sw_raw = 5'b00101;
      tick();
      if (bus.sw_rise[2] === 1'b1) begin rises++; hit_t = t; end
    end
    n_tests++;
    if (rises != 1 || hit_t != 9) begin
      n_fail++;
      $display("FAIL bounce_rise: rises=%0d at t=%0d, want 1 at t=9", rises, hit_t);
    end
    n_tests++;
    if (bus.sw_stable !== 5'b00101) begin
      n_fail++;
      $display("FAIL bounce_stable: got %b want 00101", bus.sw_stable);
    end
  endtask

  task automatic test_all_fall();
    bus.sw_raw = 5'b11111;
    for (int t = 0; t < 8; t++) tick();
    n_tests++;
    if (bus.sw_stable !== 5'b11111) begin
      n_fail++;
      $display("FAIL all_high: stable=%b want 11111", bus.sw_stable);
    end
    bus.event_clear = 1'b1;
    tick();
    bus.event_clear = 1'b0;
    bus.sw_raw = 5'b00000;
    for (int t = 0; t < 5; t++) tick();
    n_tests++;
    if (bus.sw_stable !== 5'b11111 || bus.sw_fall !== 5'b00000) begin
      n_fail++;
      $display("FAIL fall_early: stable=%b fall=%b, want 11111 00000", bus.sw_stable, bus.sw_fall);
    end
    tick();
    n_tests++;
    if (bus.sw_fall !== 5'b11111 || bus.sw_rise !== 5'b00000 || bus.sw_stable !== 5'b00000) begin
      n_fail++;
      $display("FAIL fall_edge5: fall=%b rise=%b stable=%b, want 11111 00000 00000",
               bus.sw_fall, bus.sw_rise, bus.sw_stable);
    end
    tick();
    n_tests++;
    if (bus.sw_fall !== 5'b00000 || bus.event_latched !== 5'b11111) begin
      n_fail++;
      $display("FAIL fall_latch: fall=%b latched=%b, want 00000 11111", bus.sw_fall, bus.event_latched);
    end
  endtask

  task automatic test_clear_collision();
    bus.event_clear = 1'b1;
    tick();
    bus.event_clear = 1'b0;
    bus.sw_raw = 5'b00001;
    for (int t = 0; t < 7; t++) tick();
    n_tests++;
    if (bus.event_latched !== 5'b00001) begin
      n_fail++;
      $display("FAIL collide_setup: latched=%b want 00001", bus.event_latched);
    end
    bus.sw_raw = 5'b01001;
    for (int t = 0; t < 6; t++) tick();
    n_tests++;
    if (bus.sw_rise !== 5'b01000) begin
      n_fail++;
      $display("FAIL collide_rise: rise=%b want 01000", bus.sw_rise);
    end
    bus.event_clear = 1'b1;
    tick();
    bus.event_clear = 1'b0;
    n_tests++;
    if (bus.event_latched !== 5'b01000 || bus.event_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_set_wins: latched=%b pending=%b, want 01000 1",
               bus.event_latched, bus.event_pending);
    end
    bus.event_clear = 1'b1;
    tick();
    bus.event_clear = 1'b0;
    n_tests++;
    if (bus.event_latched !== 5'b00000 || bus.event_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_clear: latched=%b pending=%b, want 00000 0",
               bus.event_latched, bus.event_pending);
    end
  endtask

  task automatic test_reset_abort();
    int rises4 = 0;
    int bad = 0;
    bus.sw_raw = 5'b11001;
    for (int t = 0; t < 4; t++) tick();
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.event_latched, bus.event_pending} !== '0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_in_reset: %0d samples nonzero, want 0", bad);
    end
    reset = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (bus.sw_rise[4] === 1'b1) rises4++;
      if (t == 4) begin
        n_tests++;
        if (bus.sw_stable !== 5'b00000) begin
          n_fail++;
          $display("FAIL abort_early: stable=%b want 00000", bus.sw_stable);
        end
      end
      if (t == 5) begin
        n_tests++;
        if (bus.sw_stable !== 5'b11001 || bus.sw_rise !== 5'b11001) begin
          n_fail++;
          $display("FAIL abort_edge5: stable=%b rise=%b, want 11001 11001", bus.sw_stable, bus.sw_rise);
        end
      end
    end
    n_tests++;
    if (rises4 != 1) begin
      n_fail++;
      $display("FAIL abort_rise_count: rise[4] pulses=%0d want 1", rises4);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_all_fall();
    test_clear_collision();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Conditions the raw board slide switches before they reach the register file's SW input, and is therefore the stage directly upstream of the CPU's switch-visible register.
- Synchronises each asynchronous switch bit into the processor clock domain and filters out contact bounce.
- Produces one-cycle rise and fall pulses per bit.
- Keeps a sticky change-event record that software-visible logic can poll and clear.

Parameters:
- WIDTH, 5, number of switch bits conditioned; each bit is fully independent.
- DEBOUNCE_CYCLES, 500000, consecutive clock cycles a synchronised level must differ from the stable value before it is accepted. 500000 gives 10 ms at 50 MHz. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 20, width of each per-bit debounce counter.

Ports:
- clock  input  1  processor clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw_raw  input  WIDTH  unsynchronised switch levels from the pins.
- sw_stable  output  WIDTH  debounced levels, fed to the register file's SW input.
- sw_rise  output  WIDTH  one-cycle pulse when the matching sw_stable bit goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse when the matching sw_stable bit goes 1->0.
- event_latched  output  WIDTH  sticky per-bit record of any stable change since the last clear.
- event_pending  output  1  OR-reduction of event_latched.
- event_clear  input  1  synchronous request to clear all of event_latched.

Behaviour:
- Reset
  - Reset is asynchronous and active-high. While reset is high, every flop is 0: sync stages, counters, sw_stable, sw_rise, sw_fall, event_latched. event_pending is therefore 0.
  - Reset asserted mid-debounce aborts the debounce; no pulse is produced.
- Synchroniser
  - Each bit passes through a two-flop chain, s1 <= sw_raw and s2 <= s1.
  - No combinational path from sw_raw reaches any output.
- Per-bit debounce, evaluated every edge
  - If s2 == sw_stable: the counter is set to 0. Any partial count is discarded, so a glitch shorter than DEBOUNCE_CYCLES is fully rejected.
  - Else if counter == DEBOUNCE_CYCLES-1: sw_stable <= s2 and the counter is set to 0. sw_rise <= s2, or sw_fall <= ~s2, for that bit.
  - Else: counter <= counter+1.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Latency
  - Number edges from 0, with sw_raw changed before edge 0 and held.
  - s2 reflects the new level after edge 1.
  - sw_stable updates at edge DEBOUNCE_CYCLES+1.
  - The rise or fall pulse is registered and is high for exactly the one cycle following that edge.
- Pulse rules
  - sw_rise and sw_fall default to 0 each cycle.
  - For any one bit, sw_rise and sw_fall are never high together.
  - Different bits may pulse on the same cycle.
- Sticky events
  - event_latched[i] <= (event_latched[i] & ~event_clear) | sw_rise[i] | sw_fall[i].
  - The pulse is the registered output, so a bit is latched one cycle after its pulse.
  - If a pulse and event_clear coincide, set wins; the event is not lost.
  - event_pending is combinational from event_latched.
- Post-reset
  - If sw_raw is held at 1 through reset release, the bit is treated as a normal 0->1 change.
  - The first edge after release is edge 0. sw_stable goes to 1 at edge DEBOUNCE_CYCLES+1, with a sw_rise pulse.

Test Plan:
Benches use DEBOUNCE_CYCLES=4 and WIDTH=5.
1. Reset, then sw_raw=5'b00001 held from edge 0 -> sw_stable[0]=1 after edge 5; sw_rise=5'b00001 for exactly one cycle; sw_fall=0; event_latched=5'b00001 one cycle later; event_pending=1.
2. From stable 0, sw_raw[1] pulsed high for 3 cycles, then low -> sw_stable stays 0; no sw_rise or sw_fall; event_pending stays 0.
3. sw_raw[2] bounces 1,0,1,0 each cycle, then holds 1 -> exactly one sw_rise[2]. It occurs 5 edges after the final 0->1 raw transition reaches edge 0 of the numbering.
4. Stable sw_raw=5'b11111, then all bits dropped together -> sw_fall=5'b11111 on a single cycle; sw_stable=0; event_latched=5'b11111.
5. With event_latched=5'b00001, event_clear asserted on the same cycle a new sw_rise[3] registers into event_latched -> event_latched becomes 5'b01000 and event_pending stays 1. A following lone event_clear then gives event_latched=0 and event_pending=0.
6. Raw bit 4 changed, then reset asserted at count 2 and released with raw still 1 -> all outputs 0 during reset. After release, sw_stable[4]=1 at edge 5 with one sw_rise[4] pulse.
